// File: rtl/rca_new_adder_pkg.sv
// Project-wide constants for the ripple-carry adder cell.
package rca_new_adder_pkg;

  // Default operand width used when the adder is instantiated without an override.
  localparam int unsigned ADDER_W = 4;

endpackage : rca_new_adder_pkg

// File: rtl/rca_new_adder_full_adder.sv
// One-bit full adder cell; purely combinational, chained by rca_new_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/rca_new_adder.sv
// N-bit ripple-carry adder with registered sum and carry-out (one-cycle latency).
module rca_new_adder
  import rca_new_adder_pkg::*;
#(
  parameter int unsigned N = ADDER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0]   c;
  logic [N-1:0] sum;

  assign c[0] = cin;

  // Carry ripples from cell 0 up to cell N-1; c[N] is the carry out of the word.
  for (genvar gi = 0; gi < N; gi++) begin : g_fa
    full_adder u_fa (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (c[gi]),
      .s    (sum[gi]),
      .cout (c[gi+1])
    );
  end

  // Output register; synchronous reset has priority over the data update.
  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= sum;
      cout <= c[N];
    end
  end

endmodule : rca_new_adder

// File: tb/tb_rca_new_adder.sv
// Self-checking bench: directed vectors and exhaustive sweep at N=4, random at N=1 and N=16.
module tb_rca_new_adder;

  logic clk = 1'b0;
  logic rst;

  logic [3:0]  a4, b4, s4;
  logic        cin4, cout4;
  logic [0:0]  a1, b1, s1;
  logic        cin1, cout1;
  logic [15:0] a16, b16, s16;
  logic        cin16, cout16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rca_new_adder #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .s(s4), .cout(cout4)
  );
  rca_new_adder #(.N(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .s(s1), .cout(cout1)
  );
  rca_new_adder #(.N(16)) u_dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .s(s16), .cout(cout16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and compare all three widths against plain arithmetic.
  task automatic cycle(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input string tag);
    int unsigned e4, e1, e16;
    rst   = r;
    a4    = a;
    b4    = b;
    cin4  = c;
    a1    = 1'($urandom);
    b1    = 1'($urandom);
    cin1  = 1'($urandom);
    a16   = 16'($urandom);
    b16   = 16'($urandom);
    cin16 = 1'($urandom);
    e4  = r ? 0 : int'(a)   + int'(b)   + int'(c);
    e1  = r ? 0 : int'(a1)  + int'(b1)  + int'(cin1);
    e16 = r ? 0 : int'(a16) + int'(b16) + int'(cin16);
    @(posedge clk);
    #1;
    check(tag,                {27'd0, cout4, s4},   e4);
    check({tag, "_n1"},       {30'd0, cout1, s1},   e1);
    check({tag, "_n16"},      {15'd0, cout16, s16}, e16);
  endtask

  initial begin
    rst = 1'b1;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0;

    cycle(1'b1, 4'b1111, 4'b1111, 1'b1, "reset0");
    cycle(1'b1, 4'b1111, 4'b1111, 1'b1, "reset1");

    cycle(1'b0, 4'b0101, 4'b1001, 1'b0, "basic");
    cycle(1'b0, 4'b1101, 4'b1010, 1'b0, "carry_out");
    cycle(1'b0, 4'b1111, 4'b0000, 1'b1, "full_ripple");
    cycle(1'b0, 4'b0000, 4'b0000, 1'b1, "cin_only");

    cycle(1'b0, 4'b0011, 4'b0100, 1'b0, "mid_pre");
    cycle(1'b1, 4'b0011, 4'b0100, 1'b0, "mid_rst");
    cycle(1'b0, 4'b0011, 4'b0100, 1'b0, "mid_post");

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      cycle(1'b0, v[3:0], v[7:4], v[8], "sweep");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rca_new_adder
